// File: rtl/pe_operand_loader.sv
// pe_operand_loader: fetches A/B/W operand vectors as memory beats and issues
// them with the instruction to the PE core over a valid/ready handshake.
module pe_operand_loader #(
    parameter int DATA_WIDTH   = 16,
    parameter int VECTOR_WIDTH = 32,
    parameter int MEM_WIDTH    = 256,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid_i,
    output logic                               cmd_ready_o,
    input  logic [31:0]                        cmd_instr_i,
    input  logic [ADDR_WIDTH-1:0]              cmd_addr_a_i,
    input  logic [ADDR_WIDTH-1:0]              cmd_addr_b_i,
    input  logic [ADDR_WIDTH-1:0]              cmd_addr_w_i,
    output logic                               mem_req_o,
    output logic [ADDR_WIDTH-1:0]              mem_addr_o,
    input  logic                               mem_ack_i,
    input  logic [MEM_WIDTH-1:0]               mem_rdata_i,
    output logic                               pe_valid_o,
    input  logic                               pe_ready_i,
    output logic [31:0]                        pe_instr_o,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0] data_a_o,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0] data_b_o,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0] weight_o,
    output logic                               busy_o
);
    localparam int BEATS = VECTOR_WIDTH * DATA_WIDTH / MEM_WIDTH;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(MEM_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

    state_t                r_state;
    logic [BW-1:0]         r_beat;
    logic [1:0]            r_op;
    logic [1:0]            r_last_op;
    logic [ADDR_WIDTH-1:0] r_addr_b;
    logic [ADDR_WIDTH-1:0] r_addr_w;
    logic [3:0]            w_opcode;

    assign w_opcode    = cmd_instr_i[31:28];
    assign cmd_ready_o = r_state == IDLE;
    assign busy_o      = r_state != IDLE;

    // r_op walks A(0), B(1), W(2); activation/normalization stop after A
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_beat     <= '0;
            r_op       <= '0;
            r_last_op  <= '0;
            r_addr_b   <= '0;
            r_addr_w   <= '0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            pe_valid_o <= 1'b0;
            pe_instr_o <= '0;
            data_a_o   <= '0;
            data_b_o   <= '0;
            weight_o   <= '0;
        end else begin
            case (r_state)
                IDLE: if (cmd_valid_i) begin
                    pe_instr_o <= cmd_instr_i;
                    mem_addr_o <= cmd_addr_a_i;
                    r_addr_b   <= cmd_addr_b_i;
                    r_addr_w   <= cmd_addr_w_i;
                    data_a_o   <= '0;
                    data_b_o   <= '0;
                    weight_o   <= '0;
                    r_beat     <= '0;
                    r_op       <= '0;
                    r_last_op  <= (w_opcode == 4'd2 || w_opcode == 4'd3) ? 2'd0 : 2'd2;
                    if (w_opcode == 4'd0) begin
                        pe_valid_o <= 1'b1;
                        r_state    <= ISSUE;
                    end else begin
                        mem_req_o <= 1'b1;
                        r_state   <= FETCH;
                    end
                end
                FETCH: if (mem_ack_i) begin
                    if (r_op == 2'd0)
                        data_a_o[r_beat*MEM_WIDTH +: MEM_WIDTH] <= mem_rdata_i;
                    else if (r_op == 2'd1)
                        data_b_o[r_beat*MEM_WIDTH +: MEM_WIDTH] <= mem_rdata_i;
                    else
                        weight_o[r_beat*MEM_WIDTH +: MEM_WIDTH] <= mem_rdata_i;
                    if (r_beat != LAST_BEAT) begin
                        r_beat     <= r_beat + 1'b1;
                        mem_addr_o <= mem_addr_o + STEP;
                    end else if (r_op != r_last_op) begin
                        r_beat     <= '0;
                        r_op       <= r_op + 2'd1;
                        mem_addr_o <= r_op == 2'd0 ? r_addr_b : r_addr_w;
                    end else begin
                        r_beat     <= '0;
                        mem_req_o  <= 1'b0;
                        pe_valid_o <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: if (pe_ready_i) begin
                    pe_valid_o <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_operand_loader.sv
// tb_pe_operand_loader: directed commands checked against a transaction-level
// model of the fetch plan, per-cycle output comparison and literal pins.
module tb_pe_operand_loader;
    localparam int AW = 32, MW = 256, VW = 512, BEATS = 2;

    logic          clk = 0, rst = 0;
    logic          cmd_valid_i = 0, cmd_ready_o;
    logic [31:0]   cmd_instr_i = 0;
    logic [AW-1:0] cmd_addr_a_i = 0, cmd_addr_b_i = 0, cmd_addr_w_i = 0;
    logic          mem_req_o, mem_ack_i = 0;
    logic [AW-1:0] mem_addr_o;
    logic [MW-1:0] mem_rdata_i;
    logic          pe_valid_o, pe_ready_i = 0, busy_o;
    logic [31:0]   pe_instr_o;
    logic [VW-1:0] data_a_o, data_b_o, weight_o;

    always #5 clk = ~clk;

    pe_operand_loader dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_instr_i(cmd_instr_i),
        .cmd_addr_a_i(cmd_addr_a_i), .cmd_addr_b_i(cmd_addr_b_i), .cmd_addr_w_i(cmd_addr_w_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .pe_valid_o(pe_valid_o), .pe_ready_i(pe_ready_i), .pe_instr_o(pe_instr_o),
        .data_a_o(data_a_o), .data_b_o(data_b_o), .weight_o(weight_o), .busy_o(busy_o)
    );

    // memory contents are a pure function of the address
    function automatic logic [MW-1:0] mem_word(input logic [AW-1:0] a);
        logic [MW-1:0] r;
        for (int j = 0; j < 8; j++)
            r[32*j +: 32] = (a * 32'h9E37_79B1) ^ (32'h0101_0101 * (j + 1)) ^ {a[15:0], a[31:16]};
        return r;
    endfunction

    assign mem_rdata_i = mem_word(mem_addr_o);

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    logic [31:0]   exp_instr;
    logic [VW-1:0] exp_a, exp_b, exp_w;
    logic [AW-1:0] exp_addrs[$];
    logic [AW-1:0] seen[$];
    int            rd_idx = 0;
    bit            chk_en = 0;

    task automatic plan(input logic [31:0] instr, input logic [AW-1:0] a, b, w);
        logic [AW-1:0] bases[3];
        logic [AW-1:0] ad;
        int n;
        n = instr[31:28] == 0 ? 0 : (instr[31:28] == 2 || instr[31:28] == 3) ? 1 : 3;
        bases = '{a, b, w};
        exp_instr = instr;
        exp_a = '0; exp_b = '0; exp_w = '0;
        exp_addrs.delete();
        for (int op = 0; op < n; op++)
            for (int k = 0; k < BEATS; k++) begin
                ad = bases[op] + AW'(32 * k);
                exp_addrs.push_back(ad);
                if (op == 0) exp_a[k*MW +: MW] = mem_word(ad);
                else if (op == 1) exp_b[k*MW +: MW] = mem_word(ad);
                else exp_w[k*MW +: MW] = mem_word(ad);
            end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (rd_idx >= exp_addrs.size()) chk("req_after_plan", VW'(mem_req_o), 0);
            else if (mem_req_o) chk("mem_addr", VW'(mem_addr_o), VW'(exp_addrs[rd_idx]));
            if (mem_req_o && mem_ack_i) rd_idx++;
            if (pe_valid_o) begin
                chk("pe_instr", VW'(pe_instr_o), VW'(exp_instr));
                chk("data_a", data_a_o, exp_a);
                chk("data_b", data_b_o, exp_b);
                chk("weight", weight_o, exp_w);
            end
            chk("busy_vs_ready", VW'(busy_o), VW'(!cmd_ready_o));
        end
    end

    // called at cycle 0 start (#1 after a rising edge) with the DUT idle
    task automatic run_cmd(input logic [31:0] instr, input logic [AW-1:0] a, b, w,
                           input int stall_beat, stall_n, ready_delay, exp_vcyc, abort_after);
        int acks = 0, vcyc = -1, stall_left = stall_n;
        seen.delete();
        plan(instr, a, b, w);
        rd_idx = 0;
        chk_en = 1;
        chk("cmd_ready_idle", VW'(cmd_ready_o), 1);
        cmd_valid_i = 1; cmd_instr_i = instr;
        cmd_addr_a_i = a; cmd_addr_b_i = b; cmd_addr_w_i = w;
        mem_ack_i = 0; pe_ready_i = 0;
        @(posedge clk); #1;
        cmd_valid_i = 0;
        for (int c = 1; c < 60; c++) begin
            if (pe_valid_o) begin vcyc = c; break; end
            if (abort_after >= 0 && acks == abort_after) begin
                chk_en = 0;
                #2 rst = 1;
                #1;
                chk("rst_req", VW'(mem_req_o), 0);
                chk("rst_valid", VW'(pe_valid_o), 0);
                chk("rst_ready", VW'(cmd_ready_o), 1);
                chk("rst_addr", VW'(mem_addr_o), 0);
                chk("rst_data_a", data_a_o, 0);
                chk("rst_busy", VW'(busy_o), 0);
                @(posedge clk); #1 rst = 0;
                return;
            end
            if (mem_req_o && acks == stall_beat && stall_left > 0) begin
                mem_ack_i = 0;
                stall_left--;
            end else begin
                mem_ack_i = 1;
                if (mem_req_o) begin acks++; seen.push_back(mem_addr_o); end
            end
            @(posedge clk); #1;
        end
        chk("pe_valid_cycle", VW'(vcyc), VW'(exp_vcyc));
        chk("read_count", VW'(acks), VW'(exp_addrs.size()));
        for (int i = 0; i < ready_delay; i++) begin
            cmd_valid_i = 1; cmd_instr_i = 32'h1234_5678; cmd_addr_a_i = 32'hDEAD_0000;
            chk("hold_valid", VW'(pe_valid_o), 1);
            chk("hold_cmd_ready", VW'(cmd_ready_o), 0);
            @(posedge clk); #1;
        end
        cmd_valid_i = 0;
        pe_ready_i = 1;
        @(posedge clk); #1;
        pe_ready_i = 0;
        chk("after_hs_valid", VW'(pe_valid_o), 0);
        chk("after_hs_ready", VW'(cmd_ready_o), 1);
    endtask

    initial begin
        logic [AW-1:0] mac_lit[6];
        logic [MW-1:0] b2020;
        mac_lit = '{32'h1000, 32'h1020, 32'h2000, 32'h2020, 32'h3000, 32'h3020};
        #1 rst = 1;
        #1;
        chk("reset_cmd_ready", VW'(cmd_ready_o), 1);
        chk("reset_req", VW'(mem_req_o), 0);
        chk("reset_addr", VW'(mem_addr_o), 0);
        chk("reset_valid", VW'(pe_valid_o), 0);
        chk("reset_instr", VW'(pe_instr_o), 0);
        chk("reset_buses", data_a_o | data_b_o | weight_o, 0);
        chk("reset_busy", VW'(busy_o), 0);
        @(posedge clk); @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;

        run_cmd(32'h1000_0000, 32'h1000, 32'h2000, 32'h3000, -1, 0, 0, 7, -1);
        chk("mac_nreads", VW'(seen.size()), 6);
        for (int i = 0; i < 6 && i < seen.size(); i++) chk("mac_addr_seq", VW'(seen[i]), VW'(mac_lit[i]));
        b2020 = mem_word(32'h2020);
        chk("mac_lane17", VW'(data_b_o[17*16 +: 16]), VW'(b2020[31:16]));
        chk("model_lane17", VW'(exp_b[17*16 +: 16]), VW'(b2020[31:16]));

        run_cmd(32'h2000_0001, 32'h1000, 32'h2000, 32'h3000, -1, 0, 0, 3, -1);
        chk("relu_nreads", VW'(seen.size()), 2);
        if (seen.size() == 2) begin
            chk("relu_addr0", VW'(seen[0]), 32'h1000);
            chk("relu_addr1", VW'(seen[1]), 32'h1020);
        end
        chk("relu_b_zero", data_b_o, 0);
        chk("relu_w_zero", weight_o, 0);

        run_cmd(32'h0000_0000, 32'h1000, 32'h2000, 32'h3000, -1, 0, 0, 1, -1);
        chk("nop_nreads", VW'(seen.size()), 0);
        chk("nop_zero", data_a_o | data_b_o | weight_o, 0);

        run_cmd(32'h2000_0002, 32'h1000, 32'h2000, 32'h3000, 1, 3, 0, 6, -1);
        run_cmd(32'h1000_00AA, 32'h4000, 32'h5040, 32'h6080, -1, 0, 5, 7, -1);
        chk("ignored_cmd_no_req", VW'(mem_req_o), 0);
        run_cmd(32'h3000_0003, 32'h7000, 32'h8000, 32'h9000, -1, 0, 1, 3, -1);
        run_cmd(32'hF000_000F, 32'hA000, 32'hB000, 32'hC000, 2, 1, 0, 8, -1);

        run_cmd(32'h2000_0000, 32'hFFFF_FFE0, 32'h0, 32'h0, -1, 0, 0, 3, -1);
        chk("wrap_nreads", VW'(seen.size()), 2);
        if (seen.size() == 2) begin
            chk("wrap_addr0", VW'(seen[0]), 32'hFFFF_FFE0);
            chk("wrap_addr1", VW'(seen[1]), 32'h0);
        end

        run_cmd(32'h1000_0000, 32'h1000, 32'h2000, 32'h3000, -1, 0, 0, 7, 3);
        run_cmd(32'h1000_0001, 32'h1000, 32'h2000, 32'h3000, -1, 0, 0, 7, -1);
        if (seen.size() > 0) chk("restart_addr0", VW'(seen[0]), 32'h1000);
        else chk("restart_nreads", VW'(seen.size()), 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pe_operand_loader.md
# pe_operand_loader

Upstream feeder for `pe_top`. Accepts one PE command at a time (instruction plus base addresses for the A, B and weight vectors). Fetches the required operand vectors from memory as 256-bit beats and assembles them into full VECTOR_WIDTH-lane buses. Presents instruction and operands to the PE core under a valid/ready handshake.

## Interface
Parameters:
- `DATA_WIDTH`, 16: bits per lane (FP16).
- `VECTOR_WIDTH`, 32: lanes per operand vector.
- `MEM_WIDTH`, 256: memory beat width. VECTOR_WIDTH*DATA_WIDTH must be a multiple of MEM_WIDTH. `BEATS` = VECTOR_WIDTH*DATA_WIDTH/MEM_WIDTH, default 2.
- `ADDR_WIDTH`, 32: byte address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  loader can accept a command.
- `cmd_instr_i`  in  32  PE instruction; bits [31:28] are the opcode.
- `cmd_addr_a_i`, `cmd_addr_b_i`, `cmd_addr_w_i`  in  ADDR_WIDTH each  operand base byte addresses.
- `mem_req_o`  out  1  read request.
- `mem_addr_o`  out  ADDR_WIDTH  read byte address.
- `mem_ack_i`  in  1  request accepted; `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i`  in  MEM_WIDTH  read data.
- `pe_valid_o`  out  1  operands valid to the PE.
- `pe_ready_i`  in  1  PE accepts.
- `pe_instr_o`  out  32  registered instruction.
- `data_a_o`, `data_b_o`, `weight_o`  out  VECTOR_WIDTH*DATA_WIDTH each  flat operand buses. Lane i occupies bits [16i+15:16i].
- `busy_o`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, FETCH, ISSUE.
- **IDLE**
  - `cmd_ready_o`=1.
  - On `cmd_valid_i`: latch instruction and all three addresses, clear operand registers, compute the fetch plan, then go to FETCH (or straight to ISSUE for a NOP).
- **Fetch plan by opcode**
  - 0 (NOP): no reads.
  - 2 (activation) and 3 (normalization): A only, BEATS reads.
  - All other opcodes (1 = MAC, 4–15): A, then B, then W, 3*BEATS reads.
  - Operands that are not fetched remain zero.
- **FETCH**
  - `mem_req_o`=1.
  - Beat k of an operand reads from base + 32*k. Address addition wraps modulo 2^ADDR_WIDTH.
  - `mem_addr_o` is held stable until `mem_ack_i`.
  - On ack, beat k of an operand is written to lanes [16k .. 16k+15]: lane 16k+j = `mem_rdata_i`[16j+15:16j].
  - The beat counter advances on ack. The next address appears the following cycle, and `mem_req_o` stays high across beats.
  - After the last ack, go to ISSUE.
- **ISSUE**
  - `pe_valid_o`=1.
  - `pe_instr_o`, `data_a_o`, `data_b_o`, `weight_o` are held constant until `pe_ready_i`.
  - On handshake, return to IDLE.
- Commands are never accepted outside IDLE. `cmd_valid_i` is ignored there with no side effects.
- `mem_ack_i` outside FETCH is ignored.

## Timing
- All outputs are registered except `cmd_ready_o` and `busy_o`, which are decoded from state.
- Reset values:
  - state = IDLE
  - `cmd_ready_o`=1
  - `mem_req_o`=0, `mem_addr_o`=0
  - `pe_valid_o`=0, `pe_instr_o`=0
  - all operand buses 0
  - `busy_o`=0
- Cycle numbering: command handshake in cycle 0.
  - `mem_req_o` rises in cycle 1.
  - With `mem_ack_i` held high, acks land in cycles 1..N, where N is the read count.
  - `pe_valid_o` rises in cycle N+1. NOP: `pe_valid_o` in cycle 1.
  - MAC with default parameters: 6 reads, `pe_valid_o` in cycle 7.
- Each cycle with `mem_ack_i` low adds one cycle. Address and request are unchanged during the stall.
- PE handshake in cycle n: `pe_valid_o`=0 and `cmd_ready_o`=1 in cycle n+1. The earliest next command handshake is cycle n+1.
- Reset mid-operation:
  - All outputs return to reset values immediately (asynchronous).
  - Partial operand data is discarded.
  - The next command fetches from beat 0.

## Test plan
- **MAC fetch:** instr 0x1000_0000, A=0x1000, B=0x2000, W=0x3000, ack always high.
  - `mem_addr_o` sequence 0x1000, 0x1020, 0x2000, 0x2020, 0x3000, 0x3020.
  - `pe_valid_o` in cycle 7.
  - Lane 17 of `data_b_o` equals bits [31:16] of the 0x2020 beat.
- **ReLU:** instr 0x2000_0001.
  - Exactly 2 reads, 0x1000 and 0x1020.
  - `data_b_o` and `weight_o` are all zero.
  - `pe_valid_o` in cycle 3.
- **NOP:** instr 0x0000_0000.
  - No `mem_req_o`.
  - `pe_valid_o` in cycle 1 with all operands zero.
- **Stalls:**
  - `mem_ack_i` low for 3 cycles on beat 1: `mem_addr_o` holds 0x1020 and `mem_req_o` stays high; `pe_valid_o` is delayed by exactly 3.
  - `pe_ready_i` low for 5 cycles: outputs stay stable, `cmd_ready_o`=0, and a concurrent `cmd_valid_i` is ignored.
- **Wrap:** A=0xFFFF_FFE0 with opcode 2.
  - Addresses 0xFFFF_FFE0, then 0x0000_0000.
- **Reset mid-fetch:** assert `rst` after 3 acks.
  - `mem_req_o`=0 and `pe_valid_o`=0 immediately; `cmd_ready_o`=1.
  - A following MAC command restarts at address A+0 and yields correct operands.
